// File: rtl/dtw_pkg.sv
// -----------------------------------------------------------------------------
// dtw_pkg
// Shared definitions for the DTW result reader: the reader state encoding,
// the record layout (three 32-bit words per query result) and the default
// width of the valid min-cost field.
// -----------------------------------------------------------------------------
package dtw_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2,
      DROP    = 2'd3
   } state_e;

   localparam int REC_WORDS        = 3;
   localparam int WORD_W           = 32;
   localparam int W_QID            = 0;
   localparam int W_POS            = 1;
   localparam int W_MIN            = 2;
   localparam int MINVAL_W_DEFAULT = 16;

   // Where the reader goes once a record has been fully disposed of.
   function automatic state_e after_record(input logic en);
      state_e nxt;
      if (en) begin
         nxt = COLLECT;
      end else begin
         nxt = IDLE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/dtw_result_reader_if.sv
// -----------------------------------------------------------------------------
// dtw_result_reader_if
// Bundles the sink-FIFO read port and the outgoing AXI-Stream port of the
// DTW result reader.
//   master : the reader's view (drives fifo_rden and the stream outputs)
//   slave  : the environment's view (FIFO + downstream stream sink)
// Signals:
//   fifo_rden, fifo_empty, fifo_dout[31:0]
//   m_axis_tdata[AXIS_WIDTH-1:0], m_axis_tvalid, m_axis_tready, m_axis_tlast
// -----------------------------------------------------------------------------
interface dtw_result_reader_if #(
   parameter int AXIS_WIDTH = 32
);

   logic                  fifo_rden;
   logic                  fifo_empty;
   logic [31:0]           fifo_dout;
   logic [AXIS_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;

   modport master (
      output fifo_rden,
      input  fifo_empty,
      input  fifo_dout,
      output m_axis_tdata,
      output m_axis_tvalid,
      input  m_axis_tready,
      output m_axis_tlast
   );

   modport slave (
      input  fifo_rden,
      output fifo_empty,
      output fifo_dout,
      input  m_axis_tdata,
      input  m_axis_tvalid,
      output m_axis_tready,
      input  m_axis_tlast
   );

endinterface

// File: rtl/dtw_result_reader.sv
// -----------------------------------------------------------------------------
// dtw_result_reader
// Drains the DTW result sink FIFO one 3-word record at a time (qid, position,
// min cost), buffers the record locally and streams it out as a 3-beat
// AXI-Stream packet with tlast on the final beat. Counts emitted records.
//
// Optional feature (macro DTW_RESULT_FILTER_EN): records whose min cost
// exceeds min_thresh are discarded and counted in drop_count instead of
// being emitted.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           allows new record collection; a record in flight completes
//   bus          dtw_result_reader_if.master (FIFO read port + AXIS output)
//   min_thresh   filter threshold (only used with the filter feature)
//   rec_count    records fully emitted (wraps)
//   drop_count   records filtered away (0 without the filter feature)
//   busy         high whenever the reader is not idle
// -----------------------------------------------------------------------------
module dtw_result_reader
   import dtw_pkg::*;
#(
   parameter int AXIS_WIDTH = 32,
   parameter int MINVAL_W   = MINVAL_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   dtw_result_reader_if.master bus,
   input  logic [MINVAL_W-1:0] min_thresh,
   output logic [31:0]         rec_count,
   output logic [31:0]         drop_count,
   output logic                busy
);

   localparam logic [1:0] LAST_IDX = 2'(W_MIN);
   localparam logic [1:0] NUM_REQ  = 2'(REC_WORDS);

   logic [1:0]                     rst_sync_q;
   logic                           rst_int_n;

   state_e                         state_q,   state_d;
   logic [1:0]                     req_cnt_q, req_cnt_d;
   logic [1:0]                     rcv_cnt_q, rcv_cnt_d;
   logic                           rd_pend_q, rd_pend_d;
   logic [REC_WORDS-1:0][WORD_W-1:0] buf_q,   buf_d;
   logic [1:0]                     beat_q,    beat_d;
   logic                           tvalid_q,  tvalid_d;
   logic                           tlast_q,   tlast_d;
   logic [WORD_W-1:0]              tdata_q,   tdata_d;
   logic [31:0]                    rec_cnt_q, rec_cnt_d;
   logic                           busy_q,    busy_d;
   logic                           fifo_rden_s;
`ifdef DTW_RESULT_FILTER_EN
   logic [31:0]                    drop_cnt_q, drop_cnt_d;
`else
   logic                           unused_thresh_s;
`endif

   // Reset is asserted asynchronously but released in step with clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   // Never more than three requests per record, and only while collecting.
   assign fifo_rden_s = (state_q == COLLECT) && !bus.fifo_empty && (req_cnt_q < NUM_REQ);

   // Next-state and datapath logic for collection, emission and filtering.
   always_comb begin
      state_d   = state_q;
      req_cnt_d = req_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      buf_d     = buf_q;
      beat_d    = beat_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tdata_d   = tdata_q;
      rec_cnt_d = rec_cnt_q;
`ifdef DTW_RESULT_FILTER_EN
      drop_cnt_d = drop_cnt_q;
`endif
      // FIFO data shows up one cycle after an accepted read.
      rd_pend_d = fifo_rden_s;

      case (state_q)
         IDLE: begin
            req_cnt_d = 2'd0;
            rcv_cnt_d = 2'd0;
            beat_d    = 2'd0;
            if (en) begin
               state_d = COLLECT;
            end else begin
               state_d = IDLE;
            end
         end

         COLLECT: begin
            if (fifo_rden_s) begin
               req_cnt_d = req_cnt_q + 2'd1;
            end else begin
               req_cnt_d = req_cnt_q;
            end
            if (rd_pend_q) begin
               buf_d[rcv_cnt_q] = bus.fifo_dout;
               rcv_cnt_d        = rcv_cnt_q + 2'd1;
               if (rcv_cnt_q == LAST_IDX) begin
`ifdef DTW_RESULT_FILTER_EN
                  // Last word is being captured now, so judge it straight off the FIFO bus.
                  if (bus.fifo_dout[MINVAL_W-1:0] > min_thresh) begin
                     state_d = DROP;
                  end else begin
                     state_d  = EMIT;
                     tvalid_d = 1'b1;
                     tdata_d  = buf_q[W_QID];
                     tlast_d  = 1'b0;
                     beat_d   = 2'd0;
                  end
`else
                  state_d  = EMIT;
                  tvalid_d = 1'b1;
                  tdata_d  = buf_q[W_QID];
                  tlast_d  = 1'b0;
                  beat_d   = 2'd0;
`endif
               end else begin
                  state_d = COLLECT;
               end
            end else begin
               rcv_cnt_d = rcv_cnt_q;
            end
         end

         EMIT: begin
            if (tvalid_q && bus.m_axis_tready) begin
               if (beat_q == LAST_IDX) begin
                  tvalid_d  = 1'b0;
                  tlast_d   = 1'b0;
                  beat_d    = 2'd0;
                  req_cnt_d = 2'd0;
                  rcv_cnt_d = 2'd0;
                  rec_cnt_d = rec_cnt_q + 32'd1;
                  state_d   = after_record(en);
               end else begin
                  beat_d  = beat_q + 2'd1;
                  tdata_d = buf_q[beat_q + 2'd1];
                  tlast_d = ((beat_q + 2'd1) == LAST_IDX);
               end
            end else begin
               // Stalled: beat, data and last all hold.
               state_d = EMIT;
            end
         end

         DROP: begin
`ifdef DTW_RESULT_FILTER_EN
            drop_cnt_d = drop_cnt_q + 32'd1;
            req_cnt_d  = 2'd0;
            rcv_cnt_d  = 2'd0;
            state_d    = after_record(en);
`else
            state_d = IDLE;
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q   <= IDLE;
         req_cnt_q <= 2'd0;
         rcv_cnt_q <= 2'd0;
         rd_pend_q <= 1'b0;
         buf_q     <= '0;
         beat_q    <= 2'd0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tdata_q   <= 32'd0;
         rec_cnt_q <= 32'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
         rd_pend_q <= rd_pend_d;
         buf_q     <= buf_d;
         beat_q    <= beat_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         tdata_q   <= tdata_d;
         rec_cnt_q <= rec_cnt_d;
         busy_q    <= busy_d;
      end
   end

`ifdef DTW_RESULT_FILTER_EN
   // Filtered-record counter.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         drop_cnt_q <= 32'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count      = 32'd0;
   assign unused_thresh_s = ^min_thresh;
`endif

   assign bus.fifo_rden     = fifo_rden_s;
   assign bus.m_axis_tvalid = tvalid_q;
   assign bus.m_axis_tlast  = tlast_q;
   assign bus.m_axis_tdata  = AXIS_WIDTH'(tdata_q);
   assign rec_count         = rec_cnt_q;
   assign busy              = busy_q;

endmodule

// File: doc/dtw_result_reader.md
Name: dtw_result_reader

Overview:
- Drains the DTW result sink FIFO: the DTW core writes one 3-word result record per query (query id, best position, min cost).
- Reassembles each record in a local buffer and streams it out as a 3-beat AXI-Stream packet with tlast on beat 2.
- Sits between the sink FIFO read port and the DMA S2MM / host-facing stream.
- Maintains record counters for host status registers.

Parameters:
- AXIS_WIDTH, 32, output stream data width; must be at least 32.
- MINVAL_W, 16, valid low bits of the min-cost word.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset; asynchronous and active-low.
- en  in  1  when 0, no new record collection starts; a record in progress completes.
- fifo_rden  out  1  sink FIFO read enable; combinational.
- fifo_empty  in  1  sink FIFO empty flag.
- fifo_dout  in  32  sink FIFO read data; valid one cycle after an accepted read.
- m_axis_tdata  out  AXIS_WIDTH  output beat data; zero-extended from 32 bits.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on beat 2 of each record.
- min_thresh  in  MINVAL_W  filter threshold; used only with the optional feature.
- rec_count  out  32  records fully emitted.
- drop_count  out  32  records discarded; constant 0 without the optional feature.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert internally):
  - State is IDLE.
  - tvalid, tlast, busy, rec_count, drop_count and all buffers are 0.
  - fifo_rden is 0 during reset.
- Record word order (fixed): word0 = qid, word1 = position, word2 = {16'b0, minval}. Words are emitted in that order, unchanged.
- FIFO read rule:
  - fifo_rden = (state==COLLECT) && !fifo_empty && req_cnt<3.
  - A read is accepted when fifo_rden is high. req_cnt increments on each accepted read.
  - The cycle after an accepted read, fifo_dout is captured into buf[rcv_cnt] and rcv_cnt increments.
  - The block never reads while not in COLLECT and never issues a 4th read for a record.
- States:
  - IDLE: if en, go to COLLECT (next cycle). Counters req_cnt and rcv_cnt are cleared.
  - COLLECT: issue reads per the rule above. When the 3rd word is captured, go to EMIT (or to DROP, see Optional Feature).
  - EMIT:
    - tvalid=1, tdata=buf[beat], tlast=(beat==2).
    - tdata, tlast and beat hold while tvalid && !tready.
    - On handshake, beat increments.
    - On the handshake of beat 2: rec_count increments; go to COLLECT if en, else IDLE.
- Latency: with an uninterrupted FIFO, the first rden is at cycle t and tvalid rises at t+4. Minimum record period is 7 cycles with tready held high.
- fifo_empty mid-record: COLLECT stalls with req_cnt held and resumes when data arrives. Partial records are never emitted.
- en deasserted mid-record: the record still completes and emits.
- tready low for any duration: no data loss, and no FIFO reads occur while in EMIT.
- Counters wrap modulo 2^32.
- rst_n asserted mid-record: the partial record is discarded. FIFO words already read are lost; host software re-arms the core after reset.

Optional Feature:
- Macro: DTW_RESULT_FILTER_EN.
- With it defined:
  - After the 3rd capture, evaluate buf[2][MINVAL_W-1:0] > min_thresh (unsigned).
  - If true, enter DROP for one cycle: no stream output, drop_count increments, then COLLECT if en, else IDLE.
  - If equal or below, proceed to EMIT.
- Without it:
  - There is no DROP state and min_thresh is ignored.
  - drop_count is tied to 0.

Decomposition:
- Shared package dtw_pkg:
  - state enum {IDLE, COLLECT, EMIT, DROP}
  - REC_WORDS=3
  - word index constants W_QID=0, W_POS=1, W_MIN=2
  - MINVAL_W default
- No sub-module is warranted: the datapath is a 3-entry buffer plus counters. Implement as one module.

Test Plan:
- Single record: FIFO preloaded with 0x00000007, 0x000012AB, 0x00000350; tready=1; en=1.
  - Expect 3 beats 0x7, 0x12AB, 0x350, with tlast only on the 3rd.
  - Expect rec_count=1 and exactly 3 rden pulses.
  - Expect tvalid rising 4 cycles after the first rden.
- Backpressure: same record with tready toggling 1,0,0,1,0,1.
  - Expect tdata/tlast stable while stalled, correct order, and no rden during EMIT.
- Starved FIFO: words arrive with 5-cycle gaps.
  - Expect rden only when !empty, no emission before word2 is captured, and correct record.
- Back-to-back: 4 records queued, tready=1.
  - Expect 12 beats, 4 tlast pulses, rec_count=4, and no extra FIFO reads after it empties.
- Reset mid-record: assert rst_n=0 after 2 words are captured.
  - Expect tvalid=0 and rec_count=0 immediately.
  - After release with en=1, expect the next 3 FIFO words to form a new record.
- Filter (DTW_RESULT_FILTER_EN), min_thresh=0x0200, records with minval 0x0100, 0x0200, 0x0201:
  - Expect the first two emitted and the third dropped.
  - Expect rec_count=2 and drop_count=1.
